periph_rr_arbiter: RTL

PERIPH_RR_ARBITER -- requirements
Module: periph_rr_arbiter

---
 rtl/periph_rr_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/periph_rr_arbiter.sv
// Round-robin arbiter funnelling NB_REQ cores onto one peripheral target port.
// Responses return in order and are routed back to the owning core via an ID FIFO.
module periph_rr_arbiter #(
  parameter int NB_REQ     = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int MAX_OUTST  = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NB_REQ-1:0]                     req_i,
  input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]     add_i,
  input  logic [NB_REQ-1:0]                     wen_i,
  input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]     wdata_i,
  input  logic [NB_REQ-1:0][BE_WIDTH-1:0]       be_i,
  output logic [NB_REQ-1:0]                     gnt_o,
  output logic [NB_REQ-1:0]                     r_valid_o,
  output logic [DATA_WIDTH-1:0]                 r_rdata_o,
  output logic                                  r_opc_o,
  output logic                                  req_o,
  output logic [ADDR_WIDTH-1:0]                 add_o,
  output logic                                  wen_o,
  output logic [DATA_WIDTH-1:0]                 wdata_o,
  output logic [BE_WIDTH-1:0]                   be_o,
  input  logic                                  gnt_i,
  input  logic                                  r_valid_i,
  input  logic [DATA_WIDTH-1:0]                 r_rdata_i,
  input  logic                                  r_opc_i,
  output logic [$clog2(MAX_OUTST):0]            outst_o,
  output logic                                  err_o
);

  localparam int IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] fifo_mem_q [MAX_OUTST];

  logic [IDX_W-1:0] rr_idx;
  logic             rr_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] head_idx;
  logic             req_valid;
  logic             full;
  logic             empty;
  logic             handshake;
  logic             pop;

  // Two-pass search: first requester at or above ptr, else the lowest one overall.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      if (!rr_found && req_i[k] && (IDX_W'(k) >= ptr_q)) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(k);
      end
    end
    for (int k = 0; k < NB_REQ; k++) begin
      if (!rr_found && req_i[k]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(k);
      end
    end
  end

  // A locked requester that drops its request yields an idle cycle before re-arbitration.
  assign win_idx   = lock_q ? lock_idx_q : rr_idx;
  assign req_valid = lock_q ? req_i[lock_idx_q] : (|req_i);
  assign full      = (outst_q == CNT_W'(MAX_OUTST));
  assign empty     = (outst_q == '0);
  assign req_o     = req_valid && !full && !rst_i;
  assign handshake = req_o && gnt_i;
  assign pop       = r_valid_i && !empty;
  assign head_idx  = fifo_mem_q[rd_ptr_q];

  assign add_o   = add_i[win_idx];
  assign wen_o   = wen_i[win_idx];
  assign wdata_o = wdata_i[win_idx];
  assign be_o    = be_i[win_idx];

  assign r_rdata_o = r_valid_i ? r_rdata_i : '0;
  assign r_opc_o   = r_valid_i ? r_opc_i : 1'b0;
  assign outst_o   = outst_q;
  assign err_o     = err_q;

  generate
    for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_core
      assign gnt_o[gi]     = handshake && (win_idx == IDX_W'(gi));
      assign r_valid_o[gi] = pop && !rst_i && (head_idx == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    outst_d    = outst_q;
    err_d      = err_q;

    if (handshake) begin
      lock_d   = 1'b0;
      ptr_d    = (win_idx == IDX_W'(NB_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else if (req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = win_idx;
    end else if (lock_q && !req_i[lock_idx_q]) begin
      lock_d = 1'b0;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({handshake, pop})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase

    if (r_valid_i && empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      outst_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      outst_q    <= outst_d;
      err_q      <= err_d;
    end
  end

  // ID storage needs no reset: validity is tracked solely by outst_q and the pointers.
  always_ff @(posedge clk_i) begin
    if (handshake) begin
      fifo_mem_q[wr_ptr_q] <= win_idx;
    end
  end

endmodule
